// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: circular buffer taking FETCH_W instructions
// and presenting ISSUE_W per cycle, with exception and branch-mispredict flush.
module if_id_queue #(
  parameter int DEPTH   = 8,
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2,
  parameter int AW      = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           flush_cause,
  input  logic [AW-1:0]                  ex_pc_i,
  input  logic [FETCH_W-1:0]             fetch_valid_i,
  input  logic [AW-1:0]                  fetch_pc_i,
  input  logic [FETCH_W*AW-1:0]          fetch_inst_i,
  input  logic [FETCH_W-1:0]             fetch_bd_i,
  output logic                           fetch_ready_o,
  input  logic [$clog2(ISSUE_W+1)-1:0]   deq_req_i,
  output logic [ISSUE_W-1:0]             out_valid_o,
  output logic [ISSUE_W*AW-1:0]          out_pc_o,
  output logic [ISSUE_W*AW-1:0]          out_inst_o,
  output logic [ISSUE_W-1:0]             out_bd_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int DW = $clog2(ISSUE_W+1);

  logic [AW-1:0]    pc_q   [DEPTH];
  logic [AW-1:0]    inst_q [DEPTH];
  logic [DEPTH-1:0] bd_q;

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] n_enq, n_deq;
  logic          cand_ok, keep;
  logic [AW-1:0] cand_pc, cand_inst;
  logic [PW-1:0] slot_idx [ISSUE_W];

  // Ready looks only at pre-edge occupancy; a same-cycle dequeue never frees space early.
  assign fetch_ready_o = (count_q <= CW'(DEPTH - FETCH_W));
  assign count_o       = count_q;

  always_comb begin
    n_enq = '0;
    for (int k = 0; k < FETCH_W; k++) begin
      if (fetch_valid_i[k]) n_enq = n_enq + CW'(1);
    end
    if (!fetch_ready_o) n_enq = '0;
    n_deq = (CW'(deq_req_i) > count_q) ? count_q : CW'(deq_req_i);

    // Delay-slot candidate: the oldest queued entry, else the incoming lane 0.
    cand_ok   = 1'b0;
    cand_pc   = pc_q[head_q];
    cand_inst = inst_q[head_q];
    if (count_q != '0) begin
      cand_ok = 1'b1;
    end else if (fetch_valid_i[0]) begin
      cand_ok   = 1'b1;
      cand_pc   = fetch_pc_i;
      cand_inst = fetch_inst_i[0 +: AW];
    end
    keep = cand_ok && (cand_pc == ex_pc_i + AW'(4));

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush && !flush_cause) begin
      tail_d  = head_q;
      count_d = '0;
    end else if (flush) begin
      tail_d  = head_q + PW'(keep);
      count_d = CW'(keep);
    end else begin
      head_d  = head_q + n_deq[PW-1:0];
      tail_d  = tail_q + n_enq[PW-1:0];
      count_d = count_q - n_deq + n_enq;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is never reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (flush && flush_cause && keep) begin
      pc_q[head_q]   <= cand_pc;
      inst_q[head_q] <= cand_inst;
      bd_q[head_q]   <= 1'b1;
    end else if (!flush && fetch_ready_o) begin
      for (int k = 0; k < FETCH_W; k++) begin
        if (fetch_valid_i[k]) begin
          pc_q[tail_q + PW'(k)]   <= fetch_pc_i + AW'(4 * k);
          inst_q[tail_q + PW'(k)] <= fetch_inst_i[k*AW +: AW];
          bd_q[tail_q + PW'(k)]   <= fetch_bd_i[k];
        end
      end
    end
  end

  always_comb begin
    out_valid_o = '0;
    out_pc_o    = '0;
    out_inst_o  = '0;
    out_bd_o    = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      slot_idx[i] = head_q + PW'(i);
      if (CW'(i) < count_q) begin
        out_valid_o[i]          = 1'b1;
        out_pc_o[i*AW +: AW]    = pc_q[slot_idx[i]];
        out_inst_o[i*AW +: AW]  = inst_q[slot_idx[i]];
        out_bd_o[i]             = bd_q[slot_idx[i]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (deq_req_i <= DW'(ISSUE_W))
        else $error("if_id_queue: deq_req_i %0d exceeds ISSUE_W", deq_req_i);
      assert (count_q <= CW'(DEPTH))
        else $error("if_id_queue: count %0d exceeds DEPTH", count_q);
      assert (count_d <= CW'(DEPTH))
        else $error("if_id_queue: next count %0d out of range", count_d);
    end
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised fetch-to-decode instruction queue; the successor of the fixed two-slot IF/ID register.
- Sits between the fetch stage and the decode/issue stage.
- Buffers up to DEPTH instructions in a circular FIFO, with FETCH_W writes and ISSUE_W reads per cycle.
- Handles exception flush and branch-mispredict flush, preserving the delay-slot instruction on mispredict.

Parameters:
- DEPTH, 8: queue entries; power of two, at least FETCH_W + ISSUE_W.
- FETCH_W, 2: instructions accepted per cycle.
- ISSUE_W, 2: instructions presented to decode per cycle.
- AW, 32: PC and instruction width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  pipeline flush request
- flush_cause  in  1  0 = exception, 1 = failed branch prediction
- ex_pc_i  in  AW  PC of the mispredicted branch in EX
- fetch_valid_i  in  FETCH_W  per-lane valid; must be contiguous from lane 0
- fetch_pc_i  in  AW  PC of lane 0; lane k PC = fetch_pc_i + 4k
- fetch_inst_i  in  FETCH_W*AW  lane k at bits [k*AW +: AW]
- fetch_bd_i  in  FETCH_W  per-lane in-delay-slot flag
- fetch_ready_o  out  1  free entries >= FETCH_W
- deq_req_i  in  clog2(ISSUE_W+1)  number of instructions decode consumes this cycle
- out_valid_o  out  ISSUE_W  slot i valid when i < count
- out_pc_o  out  ISSUE_W*AW  PCs of the oldest entries
- out_inst_o  out  ISSUE_W*AW  instructions of the oldest entries
- out_bd_o  out  ISSUE_W  delay-slot flags of the oldest entries
- count_o  out  clog2(DEPTH+1)  current occupancy

Behaviour:
- State: storage arrays for pc, inst and bd; head and tail pointers of clog2(DEPTH) bits that wrap modulo DEPTH; count register.
- Reset: head = tail = count = 0, so fetch_ready_o = 1 and out_valid_o = 0. Storage contents are don't-care; out_pc_o, out_inst_o and out_bd_o are forced to 0 for any slot whose valid bit is 0.
- Outputs: combinational from registered state. Slot i shows entry (head+i) mod DEPTH.
- Latency: an enqueued instruction is visible on the outputs the cycle after fetch.
- Dequeue: deq = min(deq_req_i, count). head += deq.
  - deq_req_i > count is legal and is clamped.
  - deq_req_i > ISSUE_W is illegal and is asserted in simulation.
- Enqueue: occurs only when fetch_ready_o = 1.
  - n = popcount(fetch_valid_i); lane k is written at (tail+k) mod DEPTH; tail += n.
  - When fetch_ready_o = 0, the fetch lanes are ignored; fetch must hold them.
- fetch_ready_o is derived from the pre-edge count only; same-cycle dequeue does not free space early.
- Simultaneous enqueue and dequeue: count_next = count - deq + n. Wrap-around is handled by pointer modulo arithmetic.
- Priority order, highest first: rst, then flush with exception, then flush with mispredict, then normal enqueue/dequeue.
- Flush with exception (flush_cause = 0): queue emptied (head = tail, count = 0). Same-cycle fetch and dequeue are discarded.
- Flush with mispredict (flush_cause = 1): same-cycle dequeue is discarded. The delay-slot candidate is chosen as follows:
  - If count > 0, the candidate is the head entry.
  - Else, if fetch_valid_i[0] = 1, the candidate is fetch lane 0.
  - If the candidate PC == ex_pc_i + 4, the queue becomes exactly that one entry with bd forced to 1, written at the head position (count = 1). Otherwise the queue is emptied.
  - All other entries and fetch lanes are discarded.
- Full: count = DEPTH is allowed. fetch_ready_o = 0 whenever count > DEPTH - FETCH_W.
- Empty: out_valid_o = 0; deq_req_i is ignored.
- count never exceeds DEPTH and never underflows. Both are asserted in simulation.
- Reset asserted mid-operation overrides flush and all traffic in the same cycle.

Test Plan:
- Reset, then fetch 2 lanes with pc 0x100, inst A/B, deq_req 0. Next cycle: count = 2, out_valid = 11, out_pc = {0x104, 0x100}.
- Fill continuously with deq_req 0. After 4 two-lane fetches: count = 8, fetch_ready_o = 0. Fifth group ignored; count stays 8.
- Steady state with fetch 2 and deq 2 for 20 cycles starting at pc 0x0. Pointers wrap; out_pc sequence strictly +4 with no gaps; count constant.
- Queue holds pc 0x200 (head), 0x204, 0x208. Assert flush with mispredict, ex_pc_i = 0x1FC. Next cycle: count = 1, out_pc[0] = 0x200, out_bd[0] = 1.
- Same queue, mispredict with ex_pc_i = 0x300. Next cycle: count = 0. A repeat with exception flush also gives count = 0.
- Empty queue, fetch lane 0 pc 0x404, flush with mispredict and ex_pc_i = 0x400. Next cycle: count = 1, bd = 1. With count = 1 and deq_req 2: dequeue clamped to 1, count = 0.
